// File: rtl/pe_result_collector.sv
// rtl/pe_result_collector.sv - drain stage for a PE chain: capture, ReLU, frame tagging, result FIFO
module pe_result_collector #(
   parameter int width   = 8,
   parameter int decimal = 4,
   parameter int NRES    = 4,
   parameter int DEPTH   = 8,
   parameter int RELU    = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 ctl,
   input  logic [width-1:0]           i_out,
   output logic [width-1:0]           o_data,
   output logic                       o_last,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic                       frame_done,
   output logic                       overflow,
   output logic                       err_extra,
   output logic [$clog2(DEPTH):0]     fill
);

   localparam int AW = $clog2(DEPTH);

   // frame index counts 0..NRES; NRES never exceeds 255 so 8 bits always suffice
   localparam logic [7:0]  NRES_L   = 8'(NRES);
   localparam logic [7:0]  LAST_IDX = 8'(NRES - 1);
   localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);

   localparam logic [1:0] CTL_LOAD = 2'd0;
   localparam logic [1:0] CTL_OUT  = 2'd1;

   // elaboration-time parameter sanity; decimal only matters to the data format upstream
   if (NRES < 1 || NRES > 255) begin : g_bad_nres
      $error("pe_result_collector: NRES out of range");
   end
   if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pe_result_collector: DEPTH must be a power of two in 2..64");
   end
   if (decimal < 0 || decimal >= width) begin : g_bad_decimal
      $error("pe_result_collector: decimal out of range");
   end

   logic [7:0]        idx_q, idx_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       fill_q, fill_d;
   logic              frame_done_q, frame_done_d;
   logic              overflow_q, overflow_d;
   logic              err_extra_q, err_extra_d;

   // each entry holds {last, value}
   logic [width:0]    mem_q [DEPTH];

   logic              capture;
   logic              extra;
   logic              pop;
   logic              push_ok;
   logic              entry_last;
   logic [width-1:0]  entry_val;

   // capture decode, ReLU clamp and FIFO push/pop arbitration
   always_comb begin
      capture    = (ctl == CTL_OUT) && (idx_q < NRES_L);
      extra      = (ctl == CTL_OUT) && (idx_q == NRES_L);
      entry_last = (idx_q == LAST_IDX);
      entry_val  = i_out;
      if (RELU != 0 && i_out[width-1]) begin
         entry_val = '0;
      end
      pop     = (fill_q != '0) && i_ready;
      // a full FIFO still takes a push when the head leaves in the same cycle
      push_ok = capture && ((fill_q < DEPTH_L) || pop);
   end

   // next-state for frame index, pointers, occupancy and status flags
   always_comb begin
      idx_d = idx_q;
      if (ctl == CTL_LOAD) begin
         idx_d = '0;
      end else if (capture) begin
         // advances even when the entry is dropped so frame alignment holds
         idx_d = idx_q + 8'd1;
      end

      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

      fill_d = fill_q;
      if (push_ok && !pop) begin
         fill_d = fill_q + (AW + 1)'(1);
      end else if (pop && !push_ok) begin
         fill_d = fill_q - (AW + 1)'(1);
      end

      frame_done_d = push_ok && entry_last;
      overflow_d   = overflow_q  || (capture && !push_ok);
      err_extra_d  = err_extra_q || extra;
   end

   // control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fill_q       <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         err_extra_q  <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fill_q       <= fill_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         err_extra_q  <= err_extra_d;
      end
   end

   // storage array; contents are don't-care until the fill counter covers them
   always_ff @(posedge clk) begin
      if (!rst && push_ok) begin
         mem_q[wr_ptr_q] <= {entry_last, entry_val};
      end
   end

   // head is masked while empty so outputs read zero after reset
   always_comb begin
      o_valid = (fill_q != '0);
      o_data  = o_valid ? mem_q[rd_ptr_q][width-1:0] : '0;
      o_last  = o_valid ? mem_q[rd_ptr_q][width]     : 1'b0;
   end

   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign err_extra  = err_extra_q;
   assign fill       = fill_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// tb/tb_pe_result_collector.sv - directed self-checking bench for pe_result_collector
module tb_pe_result_collector;

   logic       clk;
   logic       rst;
   logic [1:0] ctl;
   logic [7:0] i_out;
   logic       i_ready;

   logic [7:0] o_data_a, o_data_b;
   logic       o_last_a, o_last_b;
   logic       o_valid_a, o_valid_b;
   logic       frame_done_a, frame_done_b;
   logic       overflow_a, overflow_b;
   logic       err_extra_a, err_extra_b;
   logic [3:0] fill_a, fill_b;

   int n_checks;
   int n_fail;

   pe_result_collector #(.width(8), .decimal(4), .NRES(4), .DEPTH(8), .RELU(1)) u_dut_relu (
      .clk        (clk),
      .rst        (rst),
      .ctl        (ctl),
      .i_out      (i_out),
      .o_data     (o_data_a),
      .o_last     (o_last_a),
      .o_valid    (o_valid_a),
      .i_ready    (i_ready),
      .frame_done (frame_done_a),
      .overflow   (overflow_a),
      .err_extra  (err_extra_a),
      .fill       (fill_a)
   );

   pe_result_collector #(.width(8), .decimal(4), .NRES(4), .DEPTH(8), .RELU(0)) u_dut_pass (
      .clk        (clk),
      .rst        (rst),
      .ctl        (ctl),
      .i_out      (i_out),
      .o_data     (o_data_b),
      .o_last     (o_last_b),
      .o_valid    (o_valid_b),
      .i_ready    (i_ready),
      .frame_done (frame_done_b),
      .overflow   (overflow_b),
      .err_extra  (err_extra_b),
      .fill       (fill_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_frame();
      ctl = 2'd0;
      step();
   endtask

   task automatic capture(input logic [7:0] v);
      ctl   = 2'd1;
      i_out = v;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ctl = 2'd3;
      step();
      rst = 1'b0;
   endtask

   logic [7:0] basic_v [4];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      ctl      = 2'd3;
      i_out    = 8'h00;
      i_ready  = 1'b1;
      basic_v[0] = 8'h12;
      basic_v[1] = 8'h34;
      basic_v[2] = 8'h05;
      basic_v[3] = 8'h7F;

      // reset state
      step();
      step();
      rst = 1'b0;
      check("rst_valid", o_valid_a, 0);
      check("rst_data", o_data_a, 0);
      check("rst_last", o_last_a, 0);
      check("rst_fill", fill_a, 0);
      check("rst_done", frame_done_a, 0);
      check("rst_ovf", overflow_a, 0);
      check("rst_extra", err_extra_a, 0);

      // basic frame, consumer always ready: each value visible one cycle after capture
      new_frame();
      for (int k = 0; k < 4; k++) begin
         capture(basic_v[k]);
         check($sformatf("basic_data%0d", k), o_data_a, basic_v[k]);
         check($sformatf("basic_last%0d", k), o_last_a, (k == 3) ? 1 : 0);
         check($sformatf("basic_done%0d", k), frame_done_a, (k == 3) ? 1 : 0);
         check($sformatf("basic_fill%0d", k), fill_a, 1);
      end
      ctl = 2'd3;
      step();
      check("basic_drained", o_valid_a, 0);
      check("basic_done_off", frame_done_a, 0);

      // ReLU clamp vs pass-through
      new_frame();
      capture(8'hF0);
      check("relu_neg", o_data_a, 8'h00);
      check("pass_neg", o_data_b, 8'hF0);
      capture(8'h10);
      check("relu_pos", o_data_a, 8'h10);
      check("pass_pos", o_data_b, 8'h10);
      new_frame();
      check("relu_drain", fill_a, 0);

      // backpressure: 10 captures across frames into 8 entries
      i_ready = 1'b0;
      new_frame();
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 8) new_frame();
         capture(8'h21 + 8'(k));
         if (k == 3) check("bp_done4", frame_done_a, 1);
         if (k == 7) begin
            check("bp_fill8", fill_a, 8);
            check("bp_ovf_pre", overflow_a, 0);
            check("bp_done8", frame_done_a, 1);
         end
         if (k == 8) begin
            check("bp_ovf9", overflow_a, 1);
            check("bp_fill9", fill_a, 8);
         end
      end
      check("bp_fill10", fill_a, 8);
      ctl = 2'd3;
      step();
      check("bp_hold", o_data_a, 8'h21);
      i_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("bp_data%0d", k), o_data_a, 8'h21 + 8'(k));
         check($sformatf("bp_last%0d", k), o_last_a, (k == 3 || k == 7) ? 1 : 0);
         step();
      end
      check("bp_empty", o_valid_a, 0);
      check("bp_ovf_sticky", overflow_a, 1);

      // full FIFO with simultaneous push and pop
      do_reset();
      check("full_ovf_rst", overflow_a, 0);
      i_ready = 1'b0;
      new_frame();
      for (int k = 0; k < 4; k++) capture(8'h41 + 8'(k));
      new_frame();
      for (int k = 4; k < 8; k++) capture(8'h41 + 8'(k));
      new_frame();
      check("full_fill", fill_a, 8);
      i_ready = 1'b1;
      capture(8'h49);
      check("full_pp_fill", fill_a, 8);
      check("full_pp_ovf", overflow_a, 0);
      check("full_pp_head", o_data_a, 8'h42);
      ctl = 2'd3;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("full_data%0d", k), o_data_a, 8'h42 + 8'(k));
         step();
      end
      check("full_empty", fill_a, 0);

      // extra capture past NRES
      i_ready = 1'b0;
      new_frame();
      for (int k = 0; k < 5; k++) begin
         capture(8'h51 + 8'(k));
         if (k == 3) check("extra_pre", err_extra_a, 0);
      end
      check("extra_flag", err_extra_a, 1);
      check("extra_fill", fill_a, 4);
      ctl = 2'd3;
      i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("extra_data%0d", k), o_data_a, 8'h51 + 8'(k));
         check($sformatf("extra_last%0d", k), o_last_a, (k == 3) ? 1 : 0);
         step();
      end
      new_frame();
      i_ready = 1'b0;
      capture(8'h60);
      check("extra_new_fill", fill_a, 1);
      check("extra_new_data", o_data_a, 8'h60);
      check("extra_new_last", o_last_a, 0);
      check("extra_sticky", err_extra_a, 1);

      // mid-frame reset
      new_frame();
      capture(8'h61);
      capture(8'h62);
      do_reset();
      check("mrst_valid", o_valid_a, 0);
      check("mrst_fill", fill_a, 0);
      check("mrst_extra", err_extra_a, 0);
      check("mrst_ovf", overflow_a, 0);
      for (int k = 0; k < 4; k++) begin
         capture(8'h71 + 8'(k));
         if (k == 1) check("mrst_done2", frame_done_a, 0);
         if (k == 3) check("mrst_done4", frame_done_a, 1);
      end
      ctl = 2'd3;
      i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("mrst_data%0d", k), o_data_a, 8'h71 + 8'(k));
         check($sformatf("mrst_last%0d", k), o_last_a, (k == 3) ? 1 : 0);
         step();
      end
      check("mrst_empty", o_valid_a, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
